conv2d_dilated_seq: RTL and testbench
=====================================

CONV2D_DILATED_SEQ -- requirements
Module: conv2d_dilated_seq

Interface
REQ-001 SHALL have parameter IMG, default 32: square input height/width in pixels.
REQ-002 SHALL have parameter CIN, default 3: input channels accumulated per output pixel.
REQ-003 SHALL have parameters KH, KW, defaults 3, 5: kernel height and width.
REQ-004 SHALL have parameters PAD_H, PAD_W, defaults 2, 4: zero padding applied to top/bottom and left/right.
REQ-005 SHALL have parameters DIL_H, DIL_W, defaults 2, 2: kernel dilation.
REQ-006 SHALL have parameter STRIDE, default 1, and parameter ADDR_W, default 16: address width.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1 bit: begin one full convolution pass.
REQ-010 SHALL have port busy, output, 1 bit: a pass is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a pass.
REQ-012 SHALL have ports tap_valid (output, 1) and tap_ready (input, 1): tap handshake to the MAC datapath.
REQ-013 SHALL have ports in_addr, w_addr and out_addr, all outputs of ADDR_W bits: input, weight and output addresses for the current tap.
REQ-014 SHALL have ports tap_pad, tap_first and tap_last, all 1-bit outputs: tap lies in the padding region; tap is the first for its output pixel (clear the accumulator); tap is the last for its output pixel (write the result).

Function
REQ-015 SHALL derive OH = (IMG+2*PAD_H-DIL_H*(KH-1)-1)/STRIDE+1 and OW = (IMG+2*PAD_W-DIL_W*(KW-1)-1)/STRIDE+1 at elaboration; these give 32x32 at the defaults.
REQ-016 SHALL implement states IDLE, RUN and DONE: IDLE goes to RUN on start; RUN goes to DONE on acceptance of the final tap; DONE goes to IDLE after exactly one cycle.
REQ-017 SHALL ignore start while in the RUN or DONE state.
REQ-018 SHALL nest its loop counters in the order oh (outermost), ow, ic, kh, kw (innermost), each counter wrapping to 0 and carrying into the next outer counter.
REQ-019 SHALL assert tap_valid in every RUN cycle; counters SHALL advance only when tap_valid and tap_ready are both high in the same cycle.
REQ-020 SHALL hold all tap outputs stable while tap_valid=1 and tap_ready=0.
REQ-021 SHALL compute ih = oh*STRIDE-PAD_H+kh*DIL_H and iw = ow*STRIDE-PAD_W+kw*DIL_W as signed values wide enough that they never overflow.
REQ-022 SHALL set tap_pad=1 when ih<0, ih>=IMG, iw<0 or iw>=IMG, and SHALL drive in_addr=0 whenever tap_pad=1.
REQ-023 SHALL drive in_addr = ic*IMG*IMG+ih*IMG+iw, w_addr = ic*KH*KW+kh*KW+kw and out_addr = oh*OW+ow.
REQ-024 SHALL set tap_first=1 iff ic, kh and kw are all 0, and tap_last=1 iff ic=CIN-1, kh=KH-1 and kw=KW-1.
REQ-025 SHALL generate tap outputs combinationally from the registered counters, so the first tap is presented in the cycle after start is sampled.
REQ-026 SHALL assert busy in the RUN and DONE states and done only in DONE; tap_valid SHALL be 0 outside RUN.
REQ-027 SHALL produce exactly OH*OW*CIN*KH*KW accepted taps per pass (46080 at the defaults).

Reset
REQ-028 SHALL, while rst_n=0, immediately force state to IDLE, all counters to 0 and busy, done and tap_valid to 0, including when reset arrives mid-pass.
REQ-029 SHALL require a new start after reset is released before any pass resumes; the aborted pass is not continued.

Structure
REQ-030 SHALL place the state enum and the OH/OW derivation functions in the shared package conv2d_seq_pkg.
REQ-031 SHALL implement each loop level as an instance of sub-module conv2d_seq_cnt: a wrap counter with parameter MAX and ports en, clr, wrap and value.

Verification
REQ-032 Defaults, start pulse with tap_ready=1 -> first tap has in_addr=0, tap_pad=1 (ih=-2), w_addr=0, out_addr=0 and tap_first=1.
REQ-033 Tap at oh=2, ow=4, ic=0, kh=1, kw=2 -> ih=2, iw=4, in_addr=68, w_addr=7, out_addr=68, tap_pad=0.
REQ-034 Final tap (oh=31, ow=31, ic=2, kh=2, kw=4) -> ih=33, tap_pad=1, tap_last=1, w_addr=44, out_addr=1023; done pulses one cycle later, after 46080 accepted taps.
REQ-035 Hold tap_ready=0 for 5 cycles mid-pass -> tap_valid stays 1 and all tap outputs stay unchanged; counters advance on the first cycle ready returns to 1.
REQ-036 Assert rst_n=0 at tap 1000, then release -> busy=0 and tap_valid=0 immediately; a following start restarts at the REQ-032 values.
REQ-037 Pulse start during RUN -> no effect on counters; total accepted taps remain 46080.

Source files
------------

// File: rtl/conv2d_seq_pkg.sv
// Shared types and elaboration-time helpers for the dilated 2D convolution tap sequencer.
package conv2d_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Output extent along one axis for a padded, dilated, strided kernel.
  function automatic int out_dim(input int img, input int pad, input int dil,
                                 input int k, input int stride);
    return (img + 2 * pad - dil * (k - 1) - 1) / stride + 1;
  endfunction

  // A counter over n values never needs fewer than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2d_seq_cnt.sv
// One loop level of the convolution nest: counts 0..MAX-1 while enabled and wraps to 0.
module conv2d_seq_cnt
  import conv2d_seq_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic         wrap,
  output logic [W-1:0] value
);

  // wrap flags the terminal value so the parent can chain carries into the next level.
  assign wrap = (value == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= wrap ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/conv2d_dilated_seq.sv
// Tap address sequencer for a dilated, padded 2D convolution; walks oh/ow/ic/kh/kw and hands taps to a MAC.
module conv2d_dilated_seq
  import conv2d_seq_pkg::*;
#(
  parameter int IMG    = 32,
  parameter int CIN    = 3,
  parameter int KH     = 3,
  parameter int KW     = 5,
  parameter int PAD_H  = 2,
  parameter int PAD_W  = 4,
  parameter int DIL_H  = 2,
  parameter int DIL_W  = 2,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              tap_pad,
  output logic              tap_first,
  output logic              tap_last
);

  localparam int OH   = out_dim(IMG, PAD_H, DIL_H, KH, STRIDE);
  localparam int OW   = out_dim(IMG, PAD_W, DIL_W, KW, STRIDE);
  localparam int OH_W = cnt_width(OH);
  localparam int OW_W = cnt_width(OW);
  localparam int IC_W = cnt_width(CIN);
  localparam int KH_W = cnt_width(KH);
  localparam int KW_W = cnt_width(KW);

  state_t state, state_next;

  logic adv, clr, last_tap;
  logic kw_en, kh_en, ic_en, ow_en, oh_en;
  logic kw_wrap, kh_wrap, ic_wrap, ow_wrap, oh_wrap;
  logic [OH_W-1:0] oh_val;
  logic [OW_W-1:0] ow_val;
  logic [IC_W-1:0] ic_val;
  logic [KH_W-1:0] kh_val;
  logic [KW_W-1:0] kw_val;
  int ih, iw;

  // Counters only move on an accepted tap; outside RUN they are held at zero so every pass starts fresh.
  assign adv      = (state == RUN) && tap_ready;
  assign clr      = (state != RUN);
  assign kw_en    = adv;
  assign kh_en    = kw_en & kw_wrap;
  assign ic_en    = kh_en & kh_wrap;
  assign ow_en    = ic_en & ic_wrap;
  assign oh_en    = ow_en & ow_wrap;
  assign last_tap = kw_wrap & kh_wrap & ic_wrap & ow_wrap & oh_wrap;

  conv2d_seq_cnt #(.MAX(OH))  u_cnt_oh (.clk(clk), .rst_n(rst_n), .en(oh_en), .clr(clr), .wrap(oh_wrap), .value(oh_val));
  conv2d_seq_cnt #(.MAX(OW))  u_cnt_ow (.clk(clk), .rst_n(rst_n), .en(ow_en), .clr(clr), .wrap(ow_wrap), .value(ow_val));
  conv2d_seq_cnt #(.MAX(CIN)) u_cnt_ic (.clk(clk), .rst_n(rst_n), .en(ic_en), .clr(clr), .wrap(ic_wrap), .value(ic_val));
  conv2d_seq_cnt #(.MAX(KH))  u_cnt_kh (.clk(clk), .rst_n(rst_n), .en(kh_en), .clr(clr), .wrap(kh_wrap), .value(kh_val));
  conv2d_seq_cnt #(.MAX(KW))  u_cnt_kw (.clk(clk), .rst_n(rst_n), .en(kw_en), .clr(clr), .wrap(kw_wrap), .value(kw_val));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start is only honoured from IDLE; a pass ends on acceptance of the final tap.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    tap_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        tap_valid = 1'b1;
        if (adv && last_tap) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Input coordinates go negative in the top/left padding, so they are evaluated as signed ints.
  always_comb begin
    ih        = int'(oh_val) * STRIDE - PAD_H + int'(kh_val) * DIL_H;
    iw        = int'(ow_val) * STRIDE - PAD_W + int'(kw_val) * DIL_W;
    tap_pad   = (ih < 0) || (ih >= IMG) || (iw < 0) || (iw >= IMG);
    in_addr   = tap_pad ? '0 : ADDR_W'(int'(ic_val) * IMG * IMG + ih * IMG + iw);
    w_addr    = ADDR_W'(int'(ic_val) * KH * KW + int'(kh_val) * KW + int'(kw_val));
    out_addr  = ADDR_W'(int'(oh_val) * OW + int'(ow_val));
    tap_first = (ic_val == '0) && (kh_val == '0) && (kw_val == '0);
    tap_last  = ic_wrap && kh_wrap && kw_wrap;
  end

endmodule

// File: tb/tb_conv2d_dilated_seq.sv
// Randomised-backpressure bench for conv2d_dilated_seq, checked against an index-decomposition tap model.
module tb_conv2d_dilated_seq;

  localparam int IMG    = 32;
  localparam int CIN    = 3;
  localparam int KH     = 3;
  localparam int KW     = 5;
  localparam int PAD_H  = 2;
  localparam int PAD_W  = 4;
  localparam int DIL_H  = 2;
  localparam int DIL_W  = 2;
  localparam int STRIDE = 1;
  localparam int ADDR_W = 16;
  localparam int OH     = (IMG + 2 * PAD_H - DIL_H * (KH - 1) - 1) / STRIDE + 1;
  localparam int OW     = (IMG + 2 * PAD_W - DIL_W * (KW - 1) - 1) / STRIDE + 1;
  localparam int TOTAL  = OH * OW * CIN * KH * KW;
  localparam int CYCLE_LIMIT = 70000;

  logic clk = 1'b0;
  logic rst_n, start, tap_ready;
  logic busy, done, tap_valid, tap_pad, tap_first, tap_last;
  logic [ADDR_W-1:0] in_addr, w_addr, out_addr;

  int compared   = 0;
  int mismatched = 0;
  bit timedOut   = 1'b0;

  always #5 clk = ~clk;

  conv2d_dilated_seq #(
    .IMG(IMG), .CIN(CIN), .KH(KH), .KW(KW), .PAD_H(PAD_H), .PAD_W(PAD_W),
    .DIL_H(DIL_H), .DIL_W(DIL_W), .STRIDE(STRIDE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .in_addr(in_addr),
    .w_addr(w_addr), .out_addr(out_addr), .tap_pad(tap_pad),
    .tap_first(tap_first), .tap_last(tap_last)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected RUN-cycle outputs for the n-th tap of a pass, from a flat tap index.
  function automatic logic [63:0] expectTap(input int n);
    int kw, kh, ic, ow, oh, ih, iw;
    logic pad;
    logic [15:0] ia, wa, oa;
    kw  = n % KW;
    kh  = (n / KW) % KH;
    ic  = (n / (KW * KH)) % CIN;
    ow  = (n / (KW * KH * CIN)) % OW;
    oh  = n / (KW * KH * CIN * OW);
    ih  = oh * STRIDE - PAD_H + kh * DIL_H;
    iw  = ow * STRIDE - PAD_W + kw * DIL_W;
    pad = (ih < 0) || (ih >= IMG) || (iw < 0) || (iw >= IMG);
    ia  = pad ? 16'd0 : 16'(ic * IMG * IMG + ih * IMG + iw);
    wa  = 16'(ic * KH * KW + kh * KW + kw);
    oa  = 16'(oh * OW + ow);
    return {10'd0, ia, wa, oa, pad, (ic == 0 && kh == 0 && kw == 0),
            (ic == CIN - 1 && kh == KH - 1 && kw == KW - 1), 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic logic [63:0] observed();
    return {10'd0, in_addr, w_addr, out_addr, tap_pad, tap_first, tap_last,
            tap_valid, busy, done};
  endfunction

  task automatic applyStimulus(input logic s, input logic r);
    start     = s;
    tap_ready = r;
    @(posedge clk);
    #1;
  endtask

  // One pass: start, then track accepted taps; abortAt >= 0 drops reset when that tap is presented.
  task automatic runPass(input int abortAt, input bit randomReady);
    int n = 0;
    int cycles = 0;
    bit held = 1'b0;
    logic r, s;
    applyStimulus(1'b1, 1'b0);
    while (n < TOTAL) begin
      if (cycles >= CYCLE_LIMIT) begin
        checkOutput("timeout", 64'(n), 64'(TOTAL));
        timedOut = 1'b1;
        return;
      end
      checkOutput("tap", observed(), expectTap(n));
      if (n == 0) begin
        checkOutput("first_in_addr", in_addr, 0);
        checkOutput("first_pad", tap_pad, 1);
        checkOutput("first_w_addr", w_addr, 0);
        checkOutput("first_out_addr", out_addr, 0);
        checkOutput("first_flag", tap_first, 1);
      end
      if (n == 3067) begin
        checkOutput("mid_in_addr", in_addr, 68);
        checkOutput("mid_w_addr", w_addr, 7);
        checkOutput("mid_out_addr", out_addr, 68);
        checkOutput("mid_pad", tap_pad, 0);
      end
      if (n == TOTAL - 1) begin
        checkOutput("final_pad", tap_pad, 1);
        checkOutput("final_last", tap_last, 1);
        checkOutput("final_w_addr", w_addr, 44);
        checkOutput("final_out_addr", out_addr, 1023);
      end
      if (n == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_valid", tap_valid, 0);
        checkOutput("abort_done", done, 0);
        return;
      end
      r = 1'b1;
      if (n == 2000 && !held) begin
        for (int k = 0; k < 5; k++) begin
          applyStimulus(1'b0, 1'b0);
          checkOutput("hold", observed(), expectTap(n));
        end
        held = 1'b1;
        cycles += 5;
      end else if (randomReady) begin
        r = ($urandom_range(0, 7) != 0);
      end
      s = (n == 3000);
      applyStimulus(s, r);
      cycles++;
      if (r) n++;
    end
    checkOutput("done_pulse", {busy, done, tap_valid}, 3'b110);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_after_done", {busy, done, tap_valid}, 3'b000);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", {busy, done, tap_valid}, 3'b000);
    checkOutput("reset_w_addr", w_addr, 0);
    checkOutput("reset_out_addr", out_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("idle_no_start", {busy, done, tap_valid}, 3'b000);

    $display("[TB] pass aborted by reset at tap 1000");
    runPass(1000, 1'b0);
    if (!timedOut) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("reset_hold", {busy, done, tap_valid}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) applyStimulus(1'b0, 1'b1);
      checkOutput("no_resume_ctrl", {busy, done, tap_valid}, 3'b000);
      checkOutput("no_resume_out_addr", out_addr, 0);
      checkOutput("no_resume_w_addr", w_addr, 0);

      $display("[TB] full pass with random backpressure");
      runPass(-1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
